// File: rtl/program_loader_fsm.sv
// ---------------------------------------------------------------------------
// program_loader_fsm
//
// Purpose:
//   Fills the CPU RAM from the host byte port (ui_in) before the CPU runs.
//   For every RAM byte it steps the MAR/RAM datapath through four phases:
//   address load, host handshake, data load and RAM write. While a session is
//   in progress the loader owns the shared bus and keeps control_block off it
//   through cpu_hold. done_load is raised once every byte has been written.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            synchronous reset, active-high
//   i_programming    level; 1 = host requests or continues a load session
//   i_ui_strobe      host pulse; ui_in byte is stable (only looked at in WAIT)
//   o_ready_for_ui   1 = loader is waiting for the next host byte
//   o_done_load      sticky; last session loaded all RAM_BYTES bytes
//   o_cpu_hold       1 = control_block must drive no bus or load enables
//   o_read_ui_in     1 = gate ui_in onto the bus this cycle
//   o_addr_drive     1 = drive o_bus_addr onto the bus this cycle
//   o_bus_addr       zero-extended byte address; all-zero when not driving
//   o_n_lma          MAR address load enable, active-low
//   o_n_lmd          MAR data load enable, active-low
//   o_n_lr           RAM write strobe, active-low
//   o_byte_count     address of the byte currently being loaded
// ---------------------------------------------------------------------------
module program_loader_fsm #(
    parameter int RAM_BYTES = 16,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_programming,
    input  logic              i_ui_strobe,
    output logic              o_ready_for_ui,
    output logic              o_done_load,
    output logic              o_cpu_hold,
    output logic              o_read_ui_in,
    output logic              o_addr_drive,
    output logic [DATA_W-1:0] o_bus_addr,
    output logic              o_n_lma,
    output logic              o_n_lmd,
    output logic              o_n_lr,
    output logic [ADDR_W-1:0] o_byte_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

    typedef enum logic [2:0] {
        Idle,
        Addr,
        Wait,
        Data,
        Write,
        Done
    } loaderState_t;

    loaderState_t      r_state;
    loaderState_t      w_nextState;
    logic [ADDR_W-1:0] r_byteCount;
    logic [ADDR_W-1:0] w_nextCount;
    logic              r_doneLoad;
    logic              w_nextDone;

    logic              r_readyForUi;
    logic              r_cpuHold;
    logic              r_readUiIn;
    logic              r_addrDrive;
    logic [DATA_W-1:0] r_busAddr;
    logic              r_nLma;
    logic              r_nLmd;
    logic              r_nLr;

    // Next-state and next-counter logic. Only WAIT and the two resting states
    // look at i_programming, so a host that drops it mid-byte is only noticed
    // once the loader is back waiting. An abort in WAIT takes priority over a
    // strobe arriving on the same edge.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_byteCount;
        w_nextDone  = r_doneLoad;
        case (r_state)
            Idle: begin
                if (i_programming) begin
                    w_nextState = Addr;
                    w_nextCount = '0;
                    w_nextDone  = 1'b0;
                end
            end
            Addr: begin
                w_nextState = Wait;
            end
            Wait: begin
                if (!i_programming) begin
                    w_nextState = Idle;
                end else if (i_ui_strobe) begin
                    w_nextState = Data;
                end
            end
            Data: begin
                w_nextState = Write;
            end
            Write: begin
                if (r_byteCount == LAST_ADDR) begin
                    w_nextState = Done;
                    w_nextDone  = 1'b1;
                end else begin
                    w_nextState = Addr;
                    w_nextCount = r_byteCount + 1'b1;
                end
            end
            Done: begin
                if (!i_programming) begin
                    w_nextState = Idle;
                end
            end
            default: begin
                w_nextState = Idle;
            end
        endcase
    end

    // State register plus registered outputs. Each output is decoded from
    // the state being entered, so every output changes exactly with the
    // state and there is no path from an input straight to an output.
    // The address placed on the bus uses the incremented count so that ADDR
    // presents the byte that is about to be loaded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= Idle;
            r_byteCount  <= '0;
            r_doneLoad   <= 1'b0;
            r_readyForUi <= 1'b0;
            r_cpuHold    <= 1'b0;
            r_readUiIn   <= 1'b0;
            r_addrDrive  <= 1'b0;
            r_busAddr    <= '0;
            r_nLma       <= 1'b1;
            r_nLmd       <= 1'b1;
            r_nLr        <= 1'b1;
        end else begin
            r_state      <= w_nextState;
            r_byteCount  <= w_nextCount;
            r_doneLoad   <= w_nextDone;
            r_readyForUi <= (w_nextState == Wait);
            r_cpuHold    <= (w_nextState == Addr) || (w_nextState == Wait) ||
                            (w_nextState == Data) || (w_nextState == Write);
            r_readUiIn   <= (w_nextState == Data);
            r_addrDrive  <= (w_nextState == Addr);
            r_busAddr    <= (w_nextState == Addr) ? DATA_W'(w_nextCount) : '0;
            r_nLma       <= (w_nextState != Addr);
            r_nLmd       <= (w_nextState != Data);
            r_nLr        <= (w_nextState != Write);
        end
    end

    assign o_ready_for_ui = r_readyForUi;
    assign o_done_load    = r_doneLoad;
    assign o_cpu_hold     = r_cpuHold;
    assign o_read_ui_in   = r_readUiIn;
    assign o_addr_drive   = r_addrDrive;
    assign o_bus_addr     = r_busAddr;
    assign o_n_lma        = r_nLma;
    assign o_n_lmd        = r_nLmd;
    assign o_n_lr         = r_nLr;
    assign o_byte_count   = r_byteCount;

endmodule

// File: tb/tb_program_loader_fsm.sv
// ---------------------------------------------------------------------------
// tb_program_loader_fsm
//
// Purpose:
//   Directed self-checking bench for program_loader_fsm. A 16-byte loader and
//   a 4-byte loader share clock and reset. A small MAR/MDR/RAM model sits on
//   the 16-byte loader's bus so written RAM contents can be compared with the
//   bytes the host supplied.
// ---------------------------------------------------------------------------
module tb_program_loader_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       programming = 1'b0;
    logic       uiStrobe = 1'b0;
    logic [7:0] uiIn = 8'h00;

    logic       readyForUi, doneLoad, cpuHold, readUiIn, addrDrive;
    logic [7:0] busAddr;
    logic       nLma, nLmd, nLr;
    logic [3:0] byteCount;

    logic       programming4 = 1'b0;
    logic       uiStrobe4 = 1'b0;
    logic       readyForUi4, doneLoad4, cpuHold4, readUiIn4, addrDrive4;
    logic [7:0] busAddr4;
    logic       nLma4, nLmd4, nLr4;
    logic [1:0] byteCount4;

    int checks = 0;
    int errors = 0;
    int holdCycles = 0;
    int busViolations = 0;
    int holdStart;

    logic       clearRam = 1'b0;
    logic [7:0] ram [16];
    logic [3:0] mar = 4'h0;
    logic [7:0] mdr = 8'h00;
    logic [7:0] busValue;

    always #5 clk = ~clk;

    program_loader_fsm #(.RAM_BYTES(16), .ADDR_W(4), .DATA_W(8)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_programming(programming), .i_ui_strobe(uiStrobe),
        .o_ready_for_ui(readyForUi), .o_done_load(doneLoad), .o_cpu_hold(cpuHold),
        .o_read_ui_in(readUiIn), .o_addr_drive(addrDrive), .o_bus_addr(busAddr),
        .o_n_lma(nLma), .o_n_lmd(nLmd), .o_n_lr(nLr), .o_byte_count(byteCount)
    );

    program_loader_fsm #(.RAM_BYTES(4), .ADDR_W(2), .DATA_W(8)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_programming(programming4), .i_ui_strobe(uiStrobe4),
        .o_ready_for_ui(readyForUi4), .o_done_load(doneLoad4), .o_cpu_hold(cpuHold4),
        .o_read_ui_in(readUiIn4), .o_addr_drive(addrDrive4), .o_bus_addr(busAddr4),
        .o_n_lma(nLma4), .o_n_lmd(nLmd4), .o_n_lr(nLr4), .o_byte_count(byteCount4)
    );

    // Shared bus as the top level would build it: loader drives either the
    // host byte or the address, otherwise the bus idles at zero.
    assign busValue = readUiIn ? uiIn : (addrDrive ? busAddr : 8'h00);

    // MAR / MDR / RAM model driven by the active-low enables.
    always @(posedge clk) begin
        if (clearRam) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'hEE;
        end else begin
            if (!nLma) mar <= busValue[3:0];
            if (!nLmd) mdr <= busValue;
            if (!nLr)  ram[mar] <= mdr;
        end
    end

    // Counts held cycles and any cycle where bus ownership rules are broken.
    always @(negedge clk) begin
        if (cpuHold) holdCycles <= holdCycles + 1;
        if ((addrDrive && readUiIn) || (!cpuHold && (addrDrive || readUiIn)))
            busViolations <= busViolations + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic wipeRam();
        clearRam = 1'b1;
        @(negedge clk);
        clearRam = 1'b0;
    endtask

    task automatic waitReady(input bit sel);
        int n = 0;
        while (!(sel ? readyForUi4 : readyForUi) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("readyTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone(input bit sel);
        int n = 0;
        while (!(sel ? doneLoad4 : doneLoad) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("doneTimeout", 32'd0, 32'd1);
    endtask

    // Hands one byte over: waits for ready, strobes for one cycle.
    task automatic applyStimulus(input bit sel, input logic [7:0] value);
        waitReady(sel);
        uiIn = value;
        if (sel) uiStrobe4 = 1'b1;
        else     uiStrobe  = 1'b1;
        @(negedge clk);
        uiStrobe  = 1'b0;
        uiStrobe4 = 1'b0;
    endtask

    initial begin
        // Reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReady", 32'(readyForUi), 32'd0);
        checkOutput("rstDone", 32'(doneLoad), 32'd0);
        checkOutput("rstHold", 32'(cpuHold), 32'd0);
        checkOutput("rstReadUi", 32'(readUiIn), 32'd0);
        checkOutput("rstAddrDrv", 32'(addrDrive), 32'd0);
        checkOutput("rstBusAddr", 32'(busAddr), 32'd0);
        checkOutput("rstNLma", 32'(nLma), 32'd1);
        checkOutput("rstNLmd", 32'(nLmd), 32'd1);
        checkOutput("rstNLr", 32'(nLr), 32'd1);
        checkOutput("rstCount", 32'(byteCount), 32'd0);
        checkOutput("rstDone4", 32'(doneLoad4), 32'd0);
        rst = 1'b0;
        wipeRam();

        // Full 16-byte load with no host wait
        holdStart = holdCycles;
        programming = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h10 + 8'(i));
        waitDone(1'b0);
        checkOutput("fullDone", 32'(doneLoad), 32'd1);
        checkOutput("fullHoldInDone", 32'(cpuHold), 32'd0);
        checkOutput("fullReadyInDone", 32'(readyForUi), 32'd0);
        checkOutput("fullCount", 32'(byteCount), 32'd15);
        checkOutput("fullCycles", 32'(holdCycles - holdStart), 32'd64);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("fullRam%0d", i), 32'(ram[i]), 32'h10 + 32'(i));
        programming = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("doneSticky", 32'(doneLoad), 32'd1);
        checkOutput("idleHold", 32'(cpuHold), 32'd0);

        // Abort in WAIT of byte 5, with a strobe on the same edge
        wipeRam();
        programming = 1'b1;
        @(negedge clk);
        checkOutput("startClearsDone", 32'(doneLoad), 32'd0);
        checkOutput("startAddrDrv", 32'(addrDrive), 32'd1);
        checkOutput("startBusAddr", 32'(busAddr), 32'd0);
        checkOutput("startNLma", 32'(nLma), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h20 + 8'(i));
        waitReady(1'b0);
        checkOutput("abortCount", 32'(byteCount), 32'd5);
        programming = 1'b0;
        uiStrobe = 1'b1;
        uiIn = 8'h99;
        @(negedge clk);
        uiStrobe = 1'b0;
        checkOutput("abortHold", 32'(cpuHold), 32'd0);
        checkOutput("abortReady", 32'(readyForUi), 32'd0);
        checkOutput("abortReadUi", 32'(readUiIn), 32'd0);
        checkOutput("abortDone", 32'(doneLoad), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("abortStaysIdle", 32'(cpuHold), 32'd0);
        checkOutput("abortRam0", 32'(ram[0]), 32'h20);
        checkOutput("abortRam4", 32'(ram[4]), 32'h24);
        checkOutput("abortRam5", 32'(ram[5]), 32'hEE);

        // Strobes outside WAIT are ignored; a held strobe gives one byte per WAIT
        wipeRam();
        programming = 1'b1;
        @(negedge clk);
        checkOutput("ignAddrPhase", 32'(addrDrive), 32'd1);
        uiStrobe = 1'b1;
        uiIn = 8'h55;
        @(negedge clk);
        uiStrobe = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("ignAddrReady", 32'(readyForUi), 32'd1);
        checkOutput("ignAddrCount", 32'(byteCount), 32'd0);
        uiIn = 8'h40;
        uiStrobe = 1'b1;
        @(negedge clk);
        checkOutput("ignDataPhase", 32'(readUiIn), 32'd1);
        @(negedge clk);
        checkOutput("ignWritePhase", 32'(nLr), 32'd0);
        @(negedge clk);
        uiStrobe = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("ignWriteReady", 32'(readyForUi), 32'd1);
        checkOutput("ignWriteCount", 32'(byteCount), 32'd1);
        checkOutput("ignRam0", 32'(ram[0]), 32'h40);
        uiIn = 8'h41;
        uiStrobe = 1'b1;
        repeat (8) @(negedge clk);
        uiStrobe = 1'b0;
        checkOutput("heldCount", 32'(byteCount), 32'd3);
        checkOutput("heldReady", 32'(readyForUi), 32'd1);
        checkOutput("heldRam1", 32'(ram[1]), 32'h41);
        checkOutput("heldRam2", 32'(ram[2]), 32'h41);
        checkOutput("heldRam3", 32'(ram[3]), 32'hEE);
        programming = 1'b0;
        @(negedge clk);
        checkOutput("heldAbortHold", 32'(cpuHold), 32'd0);

        // Reset during DATA of byte 3
        wipeRam();
        programming = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h30 + 8'(i));
        waitReady(1'b0);
        uiIn = 8'h33;
        uiStrobe = 1'b1;
        @(negedge clk);
        checkOutput("rstMidData", 32'(readUiIn), 32'd1);
        rst = 1'b1;
        uiStrobe = 1'b0;
        programming = 1'b0;
        @(negedge clk);
        checkOutput("rstMidNLr", 32'(nLr), 32'd1);
        checkOutput("rstMidCount", 32'(byteCount), 32'd0);
        checkOutput("rstMidHold", 32'(cpuHold), 32'd0);
        checkOutput("rstMidReadUi", 32'(readUiIn), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstMidRam2", 32'(ram[2]), 32'h32);
        checkOutput("rstMidRam3", 32'(ram[3]), 32'hEE);

        // Four-byte build
        programming4 = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA0 + 8'(i));
        waitDone(1'b1);
        checkOutput("small Done", 32'(doneLoad4), 32'd1);
        checkOutput("smallCount", 32'(byteCount4), 32'd3);
        checkOutput("smallHold", 32'(cpuHold4), 32'd0);
        programming4 = 1'b0;
        repeat (2) @(negedge clk);
        programming4 = 1'b1;
        @(negedge clk);
        checkOutput("smallRestartAddr", 32'(addrDrive4), 32'd1);
        checkOutput("smallRestartDone", 32'(doneLoad4), 32'd0);
        checkOutput("smallRestartCount", 32'(byteCount4), 32'd0);
        programming4 = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("busExclusive", 32'(busViolations), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
